req_ack_arbiter: RTL and testbench
==================================

// Module: req_ack_arbiter
// PURPOSE
//  Shares one blocking req/ack destination among NUM_REQ requesters, each a req/ack source.
//  Round-robin arbitration; one transaction in flight; grant held from downstream req to ack.
//  Sits between several req/ack sources and a single req/ack destination (e.g. a shared config block).
// PARAMETERS
//  NUM_REQ        4    number of requester ports (2..16)
//  DATA_W         32   request data width
//  RDATA_W        32   response data width
//  TIMEOUT_CYCLES 256  watchdog limit in cycles (used only with REQ_ACK_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1                 clock, all logic on rising edge
//  rst          in   1                 asynchronous reset, active-high
//  s_req        in   NUM_REQ           per-requester req
//  s_data       in   NUM_REQ*DATA_W    per-requester data, slice i = [i*DATA_W +: DATA_W]
//  s_ack        out  NUM_REQ           per-requester ack, one-cycle pulse
//  s_rdata      out  RDATA_W           response data shared by all requesters, valid with s_ack[i]
//  m_req        out  1                 downstream req (registered)
//  m_data       out  DATA_W            downstream data (registered)
//  m_ack        in   1                 downstream ack, one-cycle pulse
//  m_rdata      in   RDATA_W           downstream response, valid with m_ack
//  grant_id     out  $clog2(NUM_REQ)   index of the current/last granted requester
//  busy         out  1                 transaction in flight (== m_req)
//  timeout_err  out  1                 sticky watchdog flag (exists only with REQ_ACK_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset values: m_req=0, m_data=0, s_ack=0, grant_id=NUM_REQ-1 (requester 0 wins first), busy=0, timeout_err=0.
//  - Requester protocol: req held high with data stable until ack; req dropped the cycle after ack.
//  - FSM IDLE: if any s_req, pick the first set index after grant_id (cyclic); register
//    m_req=1, m_data=s_data[winner], grant_id=winner; go to BUSY. Latency from s_req to m_req is 1 cycle.
//  - FSM BUSY: m_req held, m_data frozen. On m_ack: s_ack[grant_id]=m_ack (combinational,
//    0 cycles), s_rdata=m_rdata passthrough; m_req cleared next edge; go to IDLE.
//  - s_ack[i]=0 for i != grant_id and in IDLE. s_rdata is don't-care when no s_ack is set (drive m_rdata).
//  - No back-to-back: at least one IDLE cycle between transactions; with all requesting, order is 0,1,2,3,0...
//  - s_req of a non-granted port that rises or drops while BUSY has no effect until IDLE.
//  - m_ack while IDLE is ignored (no s_ack); an SVA flags it as an error.
//  - Granted requester dropping s_req while BUSY is a protocol violation; the transaction
//    still completes downstream and its ack is discarded by the requester.
//  - Reset mid-transaction: all outputs return to reset values asynchronously; in-flight transaction abandoned.
// CONFIGURATION
//  REQ_ACK_ARB_TIMEOUT_EN defined:
//   - 16-bit-capable counter cleared on entering BUSY and counting each BUSY cycle without m_ack.
//   - When it reaches TIMEOUT_CYCLES: pulse s_ack[grant_id] with s_rdata=0; set timeout_err
//     (sticky until rst); clear m_req; go to IDLE.
//   - An m_ack arriving in the same cycle wins: normal completion, no error.
//  REQ_ACK_ARB_TIMEOUT_EN undefined:
//   - No counter and no timeout_err port; BUSY waits indefinitely for m_ack.
// TESTING
//  1 Single: s_req[2]=1, data 0xA5A5_0001; m_ack after 3 cycles, m_rdata 0x1234
//    -> m_req at +1, m_data 0xA5A5_0001, s_ack[2] with s_rdata 0x1234, grant_id=2.
//  2 All 4 requesting continuously, m_ack 2 cycles after each m_req
//    -> grant order 0,1,2,3,0; >=1 idle cycle between m_req pulses; no starvation.
//  3 Requester 1 granted; s_req[3] asserted mid-BUSY with s_req[0] already high
//    -> after ack to 1, next grant is 3 (cyclic from 2), then 0.
//  4 Assert rst while BUSY with s_req[1] pending
//    -> m_req=0, s_ack=0, busy=0 immediately; after release requester 0 is granted first if requesting.
//  5 (TIMEOUT_EN, TIMEOUT_CYCLES=8) no m_ack
//    -> s_ack[grant_id] pulse at BUSY cycle 8 with s_rdata=0, timeout_err=1 held; next grant proceeds normally.
//  6 (TIMEOUT_EN) m_ack exactly at cycle 8
//    -> s_rdata=m_rdata, timeout_err stays 0.

Source files
------------

// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter sharing one blocking req/ack destination among NUM_REQ requesters.
// Optional watchdog enabled by defining REQ_ACK_ARB_TIMEOUT_EN (adds the timeout_err port).
module req_ack_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int RDATA_W        = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           s_req,
    input  logic [NUM_REQ*DATA_W-1:0]    s_data,
    output logic [NUM_REQ-1:0]           s_ack,
    output logic [RDATA_W-1:0]           s_rdata,
    output logic                         m_req,
    output logic [DATA_W-1:0]            m_data,
    input  logic                         m_ack,
    input  logic [RDATA_W-1:0]           m_rdata,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
`ifdef REQ_ACK_ARB_TIMEOUT_EN
    ,
    output logic                         timeout_err
`endif
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              load;
    logic              to_hit;
    logic [GW-1:0]     winner;
    logic [GW-1:0]     scan;
    logic              found;
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = s_data[g*DATA_W +: DATA_W];
    end

    // Cyclic search starting just after the last grant; the last granted port has lowest priority.
    always_comb begin
        winner = grant_id;
        found  = 1'b0;
        scan   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan = GW'((32'(grant_id) + k) % NUM_REQ);
            if (!found && s_req[scan]) begin
                winner = scan;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= GW'(NUM_REQ - 1);
            m_data   <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                grant_id <= winner;
                m_data   <= data_arr[winner];
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (|s_req) begin
                    state_next = BUSY;
                    load       = 1'b1;
                end
            end
            BUSY: begin
                if (m_ack || to_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ack   = '0;
        s_rdata = m_rdata;
        m_req   = (state == BUSY);
        busy    = (state == BUSY);
        if (state == BUSY) begin
            if (m_ack) begin
                s_ack[grant_id] = 1'b1;
            end else if (to_hit) begin
                s_ack[grant_id] = 1'b1;
                s_rdata         = '0;
            end
        end
    end

`ifdef REQ_ACK_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;

    // Fires in BUSY cycle TIMEOUT_CYCLES; a simultaneous m_ack takes precedence.
    always_comb begin
        to_hit = (state == BUSY) && !m_ack && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (load) begin
                to_cnt <= '0;
            end else if (state == BUSY) begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (to_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    always_comb begin
        to_hit = 1'b0;
    end
`endif

    a_no_ack_in_idle : assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> !m_ack);

    a_ack_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(s_ack));

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Scoreboard bench for req_ack_arbiter: directed requester/responder stimulus, decoupled monitor.
// Timeout scenarios are exercised only when REQ_ACK_ARB_TIMEOUT_EN is defined.
module tb_req_ack_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int RDATA_W = 32;
    localparam int TO      = 8;
    localparam int GW      = $clog2(NUM_REQ);

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        s_req;
    logic [NUM_REQ*DATA_W-1:0] s_data;
    logic [NUM_REQ-1:0]        s_ack;
    logic [RDATA_W-1:0]        s_rdata;
    logic                      m_req;
    logic [DATA_W-1:0]         m_data;
    logic                      m_ack;
    logic [RDATA_W-1:0]        m_rdata;
    logic [GW-1:0]             grant_id;
    logic                      busy;
`ifdef REQ_ACK_ARB_TIMEOUT_EN
    logic                      timeout_err;
`endif

    req_ack_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W(DATA_W),
        .RDATA_W(RDATA_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_req(s_req),
        .s_data(s_data),
        .s_ack(s_ack),
        .s_rdata(s_rdata),
        .m_req(m_req),
        .m_data(m_data),
        .m_ack(m_ack),
        .m_rdata(m_rdata),
        .grant_id(grant_id),
        .busy(busy)
`ifdef REQ_ACK_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
        int                cyc;
        logic              terr;
    } grant_t;

    typedef struct {
        int                 id;
        logic [RDATA_W-1:0] rdata;
        int                 lat;
        logic               terr;
    } ack_t;

    grant_t             grant_q[$];
    ack_t               ack_q[$];
    logic [RDATA_W-1:0] rdata_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic wd_expired = 1'b0;
    logic end_chk    = 1'b0;
    logic end_done   = 1'b0;

    int                 pend [NUM_REQ];
    int                 txn  [NUM_REQ];
    logic [DATA_W-1:0]  base [NUM_REQ];
    int                 resp_delay;
    int                 bc;
    logic [NUM_REQ-1:0] acked;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_grant(input int id, input logic [DATA_W-1:0] data, input int c, input logic terr);
        grant_t g;
        g.id = id; g.data = data; g.cyc = c; g.terr = terr;
        grant_q.push_back(g);
    endtask

    task automatic exp_ack(input int id, input logic [RDATA_W-1:0] rd, input int lat, input logic terr);
        ack_t a;
        a.id = id; a.rdata = rd; a.lat = lat; a.terr = terr;
        ack_q.push_back(a);
    endtask

    // One clock of requester + responder behaviour; inputs change 2 time units after posedge.
    task automatic step();
        @(negedge clk);
        acked = s_ack;
        @(posedge clk);
        #2;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acked[i]) begin
                s_req[i] = 1'b0;
                txn[i]++;
                if (pend[i] > 0) pend[i]--;
            end else begin
                s_req[i] = (pend[i] > 0);
            end
            s_data[i*DATA_W +: DATA_W] = base[i] + DATA_W'(txn[i]);
        end
        m_ack = 1'b0;
        if (m_req) begin
            bc++;
            if (bc == resp_delay) begin
                m_ack = 1'b1;
                if (rdata_q.size() > 0) m_rdata = rdata_q.pop_front();
            end
        end else begin
            bc = 0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int  n = 0;
        bit  active = 1'b1;
        while (active && n < budget) begin
            active = m_req || (grant_q.size() != 0) || (ack_q.size() != 0);
            for (int i = 0; i < NUM_REQ; i++) if (pend[i] > 0) active = 1'b1;
            if (active) begin
                step();
                n++;
            end
        end
        if (active) wd_expired = 1'b1;
        step();
    endtask

    task automatic clear_txn();
        for (int i = 0; i < NUM_REQ; i++) txn[i] = 0;
    endtask

    // Monitor: the only process that compares and steps the counters.
    initial begin
        grant_t             g;
        ack_t               a;
        logic               prev_mreq  = 1'b0;
        logic               prev_ack   = 1'b0;
        logic               rst_seen   = 1'b0;
        logic               wd_seen    = 1'b0;
        int                 rise_cyc   = 0;
        logic [NUM_REQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!rst_seen) begin
                    chk("rst_m_req", m_req, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_s_ack", s_ack, 0);
                    chk("rst_grant_id", grant_id, NUM_REQ - 1);
                    chk("rst_m_data", m_data, 0);
`ifdef REQ_ACK_ARB_TIMEOUT_EN
                    chk("rst_timeout_err", timeout_err, 0);
`endif
                    rst_seen = 1'b1;
                end
                prev_mreq = 1'b0;
                prev_ack  = 1'b0;
            end else begin
                rst_seen = 1'b0;
                if (prev_ack) chk("idle_gap_after_ack", m_req, 0);
                chk("busy_eq_m_req", busy, m_req);
                if (m_req && !prev_mreq) begin
                    rise_cyc = cyc;
                    if (grant_q.size() == 0) begin
                        chk("unexpected_grant", grant_id, NUM_REQ);
                    end else begin
                        g = grant_q.pop_front();
                        chk("grant_id", grant_id, g.id);
                        chk("m_data", m_data, g.data);
                        if (g.cyc >= 0) chk("grant_cycle", cyc, g.cyc);
`ifdef REQ_ACK_ARB_TIMEOUT_EN
                        chk("grant_timeout_err", timeout_err, g.terr);
`endif
                    end
                end
                if (s_ack != '0) begin
                    if (ack_q.size() == 0) begin
                        chk("unexpected_ack", s_ack, 0);
                    end else begin
                        a = ack_q.pop_front();
                        oh = '0;
                        oh[a.id] = 1'b1;
                        chk("s_ack", s_ack, oh);
                        chk("s_rdata", s_rdata, a.rdata);
                        chk("ack_grant_id", grant_id, a.id);
                        chk("ack_latency", cyc - rise_cyc, a.lat);
`ifdef REQ_ACK_ARB_TIMEOUT_EN
                        chk("ack_timeout_err", timeout_err, a.terr);
`endif
                    end
                end
                prev_ack  = |s_ack;
                prev_mreq = m_req;
            end
            if (wd_expired != wd_seen) begin
                chk("wait_budget", wd_expired, 0);
                wd_seen = wd_expired;
            end
            if (end_chk && !end_done) begin
                chk("grant_q_drained", grant_q.size(), 0);
                chk("ack_q_drained", ack_q.size(), 0);
                end_done = 1'b1;
            end
        end
    end

    initial begin
        s_req = '0; s_data = '0; m_ack = 1'b0; m_rdata = '0;
        resp_delay = 0; bc = 0; acked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 0; txn[i] = 0; base[i] = '0;
        end
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Single request from port 2, ack in BUSY cycle 3.
        base[2] = 32'hA5A5_0001;
        resp_delay = 3;
        rdata_q.push_back(32'h0000_1234);
        exp_grant(2, 32'hA5A5_0001, cyc + 2, 1'b0);
        exp_ack(2, 32'h0000_1234, 2, 1'b0);
        pend[2] = 1;
        wait_idle(40);

        // Reset while BUSY on port 3 with port 1 pending.
        base[0] = 32'h0000_A000; base[1] = 32'h0000_B000;
        base[2] = 32'h0000_C000; base[3] = 32'h0000_D000;
        clear_txn();
        resp_delay = 0;
        exp_grant(3, 32'h0000_D000, cyc + 2, 1'b0);
        pend[3] = 1;
        repeat (3) step();
        pend[1] = 1;
        repeat (2) step();
        rst = 1'b1;
        step();

        // After release all four request; port 0 goes first and twice overall.
        pend[0] = 2; pend[2] = 1;
        resp_delay = 2;
        rdata_q.push_back(32'h0000_00D0); rdata_q.push_back(32'h0000_00D1);
        rdata_q.push_back(32'h0000_00D2); rdata_q.push_back(32'h0000_00D3);
        rdata_q.push_back(32'h0000_00D4);
        step();
        exp_grant(0, 32'h0000_A000, cyc + 1, 1'b0);
        exp_grant(1, 32'h0000_B000, -1, 1'b0);
        exp_grant(2, 32'h0000_C000, -1, 1'b0);
        exp_grant(3, 32'h0000_D000, -1, 1'b0);
        exp_grant(0, 32'h0000_A001, -1, 1'b0);
        exp_ack(0, 32'h0000_00D0, 1, 1'b0);
        exp_ack(1, 32'h0000_00D1, 1, 1'b0);
        exp_ack(2, 32'h0000_00D2, 1, 1'b0);
        exp_ack(3, 32'h0000_00D3, 1, 1'b0);
        exp_ack(0, 32'h0000_00D4, 1, 1'b0);
        rst = 1'b0;
        wait_idle(100);

        // Port 1 wins over 0; port 3 rises mid-BUSY and goes next, then 0.
        base[0] = 32'h3000_0000; base[1] = 32'h3100_0000; base[3] = 32'h3300_0000;
        clear_txn();
        resp_delay = 4;
        rdata_q.push_back(32'hE100_0001); rdata_q.push_back(32'hE100_0002);
        rdata_q.push_back(32'hE100_0003);
        exp_grant(1, 32'h3100_0000, cyc + 2, 1'b0);
        exp_grant(3, 32'h3300_0000, -1, 1'b0);
        exp_grant(0, 32'h3000_0000, -1, 1'b0);
        exp_ack(1, 32'hE100_0001, 3, 1'b0);
        exp_ack(3, 32'hE100_0002, 3, 1'b0);
        exp_ack(0, 32'hE100_0003, 3, 1'b0);
        pend[0] = 1; pend[1] = 1;
        repeat (2) step();
        pend[3] = 1;
        wait_idle(100);

`ifdef REQ_ACK_ARB_TIMEOUT_EN
        // No m_ack: watchdog completes at BUSY cycle 8 with zero data.
        base[2] = 32'h5000_0002;
        clear_txn();
        resp_delay = 0;
        exp_grant(2, 32'h5000_0002, cyc + 2, 1'b0);
        exp_ack(2, 32'h0000_0000, 7, 1'b0);
        pend[2] = 1;
        wait_idle(60);

        base[1] = 32'h5100_0001;
        resp_delay = 2;
        rdata_q.push_back(32'h0000_00F1);
        exp_grant(1, 32'h5100_0001, -1, 1'b1);
        exp_ack(1, 32'h0000_00F1, 1, 1'b1);
        pend[1] = 1;
        wait_idle(40);

        // m_ack in exactly BUSY cycle 8 beats the watchdog.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        base[3] = 32'h6300_0003; base[0] = 32'h6000_0000;
        clear_txn();
        resp_delay = 8;
        rdata_q.push_back(32'h0000_00F2);
        exp_grant(3, 32'h6300_0003, cyc + 2, 1'b0);
        exp_ack(3, 32'h0000_00F2, 7, 1'b0);
        pend[3] = 1;
        wait_idle(60);

        resp_delay = 1;
        rdata_q.push_back(32'h0000_00F3);
        exp_grant(0, 32'h6000_0000, -1, 1'b0);
        exp_ack(0, 32'h0000_00F3, 0, 1'b0);
        pend[0] = 1;
        wait_idle(40);
`endif

        end_chk = 1'b1;
        for (int k = 0; k < 5 && !end_done; k++) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
